// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Moves bytes from two requesters into a show-ahead TX FIFO and hands them, one
// at a time, to a UART transmitter.
//
// Write side (combinational): a round-robin arbiter picks between req0 (CPU
// store path) and req1 (debug/monitor path). The grant is suppressed while the
// FIFO is full, while flush is asserted or while reset is asserted. The ack of
// the granted requester is the FIFO write strobe.
//
// Read side (FSM): IDLE -> LOAD (pop head, capture byte) -> START (tx_start
// pulse, count byte) -> WAIT_BUSY (transmitter must raise tx_busy within 8
// cycles, else tx_error) -> WAIT_DONE (until tx_busy drops) -> IDLE.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous reset, active low
//   req0/data0/ack0  requester 0 handshake (req held until ack)
//   req1/data1/ack1  requester 1 handshake (req held until ack)
//   fifo_full      FIFO write-side full flag
//   fifo_write     FIFO push strobe
//   fifo_in_data   FIFO push data
//   fifo_empty     FIFO read-side empty flag
//   fifo_out_data  FIFO head byte (show-ahead)
//   fifo_read      FIFO pop strobe
//   fifo_clear     FIFO asynchronous clear (flush or reset)
//   flush          software flush, level
//   tx_data        byte presented to the transmitter
//   tx_start       one-cycle start pulse to the transmitter
//   tx_busy        transmitter busy
//   tx_count       bytes handed to the transmitter (wrapping)
//   tx_error       sticky: transmitter never acknowledged a start
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    input  logic              fifo_full,
    output logic              fifo_write,
    output logic [DATA_W-1:0] fifo_in_data,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_out_data,
    output logic              fifo_read,
    output logic              fifo_clear,
    input  logic              flush,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [15:0]       tx_count,
    output logic              tx_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              fifo_read_q, fifo_read_d;
    logic [15:0]       tx_count_q, tx_count_d;
    logic              tx_error_q, tx_error_d;
    logic [2:0]        timeout_q, timeout_d;
    logic              last_grant_q, last_grant_d;

    logic              grant1;
    logic              wr_ok;

    // ---------------------------------------------------------------------
    // Write side: round-robin arbitration, fully combinational.
    // last_grant_q holds the index of the requester granted most recently;
    // on a tie the other one wins. It resets to 1 so requester 0 wins the
    // first tie.
    // ---------------------------------------------------------------------
    always_comb begin
        grant1       = req1 & (~req0 | ~last_grant_q);
        wr_ok        = (req0 | req1) & ~fifo_full & ~flush & reset;
        last_grant_d = wr_ok ? grant1 : last_grant_q;
    end

    assign fifo_write   = wr_ok;
    assign ack0         = wr_ok & ~grant1;
    assign ack1         = wr_ok & grant1;
    assign fifo_in_data = grant1 ? data1 : data0;
    assign fifo_clear   = flush | ~reset;

    // ---------------------------------------------------------------------
    // Read side: next-state and registered-output logic.
    // fifo_read and tx_start are registered so they are high exactly while
    // the FSM sits in LOAD and START respectively.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        fifo_read_d = 1'b0;
        tx_count_d  = tx_count_q;
        tx_error_d  = tx_error_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                // Flush only gates leaving IDLE; a byte already in flight
                // runs to completion.
                if (~fifo_empty & ~tx_busy & ~flush) begin
                    state_d     = S_LOAD;
                    tx_data_d   = fifo_out_data;
                    fifo_read_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d    = S_START;
                tx_start_d = 1'b1;
                timeout_d  = 3'd0;
            end
            S_START: begin
                state_d    = S_WAIT_BUSY;
                tx_count_d = tx_count_q + 16'd1;
            end
            S_WAIT_BUSY: begin
                // timeout_q counts completed WAIT_BUSY cycles; the eighth
                // cycle without tx_busy gives up on this byte.
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timeout_q == 3'd7) begin
                    state_d    = S_IDLE;
                    tx_error_d = 1'b1;
                end else begin
                    timeout_d = timeout_q + 3'd1;
                end
            end
            S_WAIT_DONE: begin
                if (~tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            fifo_read_q  <= 1'b0;
            tx_count_q   <= 16'h0000;
            tx_error_q   <= 1'b0;
            timeout_q    <= 3'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            fifo_read_q  <= fifo_read_d;
            tx_count_q   <= tx_count_d;
            tx_error_q   <= tx_error_d;
            timeout_q    <= timeout_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign fifo_read = fifo_read_q;
    assign tx_count  = tx_count_q;
    assign tx_error  = tx_error_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have the following ports, one per line (name, direction, width, meaning).
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 (CPU store path) byte request; held until ack0.
- data0  in  8  requester 0 byte.
- ack0  out  1  requester 0 byte accepted this cycle.
- req1  in  1  requester 1 (debug/monitor path) byte request; held until ack1.
- data1  in  8  requester 1 byte.
- ack1  out  1  requester 1 byte accepted this cycle.
- fifo_full  in  1  TX FIFO write-side full.
- fifo_write  out  1  TX FIFO write request.
- fifo_in_data  out  8  TX FIFO write data.
- fifo_empty  in  1  TX FIFO read-side empty.
- fifo_out_data  in  8  TX FIFO head byte (show-ahead: valid whenever fifo_empty=0).
- fifo_read  out  1  TX FIFO read request (pop head).
- fifo_clear  out  1  TX FIFO asynchronous clear, active-high.
- flush  in  1  software flush request, level.
- tx_data  out  8  byte to UART transmitter.
- tx_start  out  1  one-cycle start pulse to UART transmitter.
- tx_busy  in  1  UART transmitter busy.
- tx_count  out  16  bytes handed to transmitter, wraps 0xFFFF->0x0000.
- tx_error  out  1  sticky: transmitter failed to acknowledge tx_start.

Function
REQ-002 Write side SHALL be combinational: fifo_write=1 iff (req0|req1) & ~fifo_full & ~flush & reset.
REQ-003 Grant SHALL be round-robin: when both req asserted, grant the requester not granted last; single request always granted; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-004 fifo_in_data SHALL be data of granted requester; ack of granted requester SHALL equal fifo_write; the other ack SHALL be 0; at most one ack per cycle.
REQ-005 Last-grant pointer SHALL update only on cycles where fifo_write=1.
REQ-006 Read side SHALL be an FSM with states IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE->LOAD when fifo_empty=0 & tx_busy=0 & flush=0; on that edge tx_data SHALL capture fifo_out_data.
REQ-008 fifo_read SHALL be 1 exactly while state=LOAD (one cycle); LOAD->START unconditionally.
REQ-009 tx_start SHALL be 1 exactly while state=START (one cycle); START->WAIT_BUSY; tx_count SHALL increment on this edge.
REQ-010 WAIT_BUSY->WAIT_DONE when tx_busy=1; 3-bit timeout counter cleared on START entry; if 8 cycles elapse in WAIT_BUSY with tx_busy=0, go to IDLE and set tx_error.
REQ-011 WAIT_DONE->IDLE when tx_busy=0; minimum byte-to-byte spacing is therefore 4 cycles plus transmitter busy time.
REQ-012 fifo_clear SHALL be flush | ~reset (combinational).
REQ-013 Flush SHALL not abort a byte already in LOAD/START/WAIT_*; it completes normally; FSM SHALL not leave IDLE while flush=1.
REQ-014 Simultaneous FIFO write and read in one cycle SHALL be permitted; fifo_full/fifo_empty are the FIFO's own flags, no local occupancy count.
REQ-015 tx_error SHALL clear only on reset.

Reset
REQ-016 reset=0 SHALL immediately force: state=IDLE, tx_data=0x00, tx_start=0, fifo_read=0, tx_count=0x0000, tx_error=0, timeout=0, last-grant=1, fifo_write=0, ack0=ack1=0, fifo_clear=1.
REQ-017 Reset asserted mid-byte SHALL abandon the byte without a further tx_start; no state survives.

Verification
REQ-018 req0=1 data0=0x41, empty FIFO, tx_busy model 10 cycles -> ack0 same cycle; FIFO pop 1 cycle after fifo_empty falls; tx_data=0x41, one tx_start pulse, tx_count=1.
REQ-019 req0 & req1 held continuously with distinct data -> acks alternate 0,1,0,1...; FIFO contents interleave in that order.
REQ-020 fifo_full=1 with req0=1 -> fifo_write=0, ack0=0 until full drops, then ack0=1 same cycle.
REQ-021 tx_busy tied 0 after tx_start -> IDLE after 8 WAIT_BUSY cycles, tx_error=1, tx_count still incremented.
REQ-022 flush asserted during WAIT_DONE with 3 bytes queued -> fifo_clear=1, no acks, current byte finishes, no further tx_start while flush=1.
REQ-023 tx_count preloaded by 0xFFFF sends -> next send wraps to 0x0000; reset mid-WAIT_DONE -> all outputs per REQ-016 asynchronously.
